// File: rtl/snake_head_mover_pkg.sv
// snake_pkg: codes and widths shared by the snake mover and the navigation state machine
// No ports; provides direction codes, game state codes, coordinate/length widths and grid defaults.
package snake_pkg;
    typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
    localparam int X_W = 6;
    localparam int Y_W = 5;
    localparam int L_W = 6;
    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;
endpackage

// File: rtl/snake_head_mover_if.sv
// snake_head_mover_if: control inputs and status/readout outputs of the snake head mover
// master (game/nav side) drives dir, start, grow, seg_idx; slave (mover) drives segment readout,
// head position, len, step, dead and state.
interface snake_head_mover_if;
    import snake_pkg::*;
    logic [1:0] dir;
    logic start;
    logic grow;
    logic [4:0] seg_idx;
    logic [X_W-1:0] seg_x;
    logic [Y_W-1:0] seg_y;
    logic seg_valid;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [L_W-1:0] len;
    logic step;
    logic dead;
    logic [1:0] state;
    modport master(
        output dir, start, grow, seg_idx,
        input seg_x, seg_y, seg_valid, head_x, head_y, len, step, dead, state
    );
    modport slave(
        input dir, start, grow, seg_idx,
        output seg_x, seg_y, seg_valid, head_x, head_y, len, step, dead, state
    );
endinterface

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: divides the clock into one-cycle step pulses while enabled
// Ports: clk, rst (async, active high), en (count enable, counter held at 0 when low),
// tick (high during the terminal-count cycle).
module snake_tick_gen #(
    parameter int TICK_DIV = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (!en || tick) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/snake_head_mover.sv
// snake_head_mover: moves the snake head once per tick, keeps body history, grows and detects self-collision
// Ports: clk, rst (async, active high); bus (slave modport) with dir/start/grow/seg_idx in and
// seg_x/seg_y/seg_valid readout, head_x/head_y, len, step strobe, dead and state out.
// Build option: SNAKE_WALL_KILL_EN turns leaving the grid into a collision instead of wrapping.
module snake_head_mover
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int TICK_DIV = 10000000,
    parameter int INIT_LEN = 4,
    parameter int MAX_LEN = 32
) (
    input logic clk,
    input logic rst,
    snake_head_mover_if.slave bus
);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    state_t st, st_nx;
    dir_t mdir, eff;
    logic [X_W-1:0] xs [MAX_LEN];
    logic [Y_W-1:0] ys [MAX_LEN];
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic [L_W-1:0] len_q;
    logic pend, step_q, tick, grows, body_hit, hit, restart;

    function automatic logic [Y_W-1:0] init_y(input int i);
        return Y_W'((GRID_H / 2 + i) % GRID_H);
    endfunction

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(st == RUN),
        .tick(tick)
    );

    // a grow only lengthens the body below MAX_LEN; otherwise the tail still vacates
    assign grows = (pend || bus.grow) && len_q < L_W'(MAX_LEN);
    assign restart = st == DEAD && bus.start;

    always_comb begin
        eff = ((bus.dir ^ mdir) == 2'b10) ? mdir : dir_t'(bus.dir);
        nx = xs[0];
        ny = ys[0];
        if (eff == RIGHT) nx = (xs[0] == X_MAX) ? '0 : xs[0] + X_W'(1);
        if (eff == LEFT) nx = (xs[0] == '0) ? X_MAX : xs[0] - X_W'(1);
        if (eff == DOWN) ny = (ys[0] == Y_MAX) ? '0 : ys[0] + Y_W'(1);
        if (eff == UP) ny = (ys[0] == '0) ? Y_MAX : ys[0] - Y_W'(1);
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len_q) - 1 + int'(grows) && xs[i] == nx && ys[i] == ny) body_hit = 1'b1;
    end

`ifdef SNAKE_WALL_KILL_EN
    logic off;
    assign off = (eff == UP && ys[0] == '0) || (eff == DOWN && ys[0] == Y_MAX) ||
                 (eff == LEFT && xs[0] == '0) || (eff == RIGHT && xs[0] == X_MAX);
    assign hit = body_hit || off;
`else
    assign hit = body_hit;
`endif

    always_comb begin
        st_nx = st;
        if (st == IDLE && bus.start) st_nx = RUN;
        if (st == RUN && tick && hit) st_nx = DEAD;
        if (restart) st_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdir <= UP;
            len_q <= L_W'(INIT_LEN);
            pend <= 1'b0;
            step_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                xs[i] <= X_W'(GRID_W / 2);
                ys[i] <= init_y(i);
            end
        end else if (restart) begin
            mdir <= UP;
            len_q <= L_W'(INIT_LEN);
            pend <= 1'b0;
            step_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                xs[i] <= X_W'(GRID_W / 2);
                ys[i] <= init_y(i);
            end
        end else begin
            step_q <= tick && !hit;
            if (st == RUN && bus.grow) pend <= 1'b1;
            if (tick) mdir <= eff;
            if (tick && !hit) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    xs[i] <= xs[i-1];
                    ys[i] <= ys[i-1];
                end
                xs[0] <= nx;
                ys[0] <= ny;
                len_q <= grows ? len_q + L_W'(1) : len_q;
                pend <= 1'b0;
            end
        end
    end

    assign bus.seg_valid = {1'b0, bus.seg_idx} < len_q;
    assign bus.seg_x = (int'(bus.seg_idx) < MAX_LEN) ? xs[bus.seg_idx] : '0;
    assign bus.seg_y = (int'(bus.seg_idx) < MAX_LEN) ? ys[bus.seg_idx] : '0;
    assign bus.head_x = xs[0];
    assign bus.head_y = ys[0];
    assign bus.len = len_q;
    assign bus.step = step_q;
    assign bus.dead = st == DEAD;
    assign bus.state = st;
endmodule
